// File: rtl/alu_muldiv_sequencer_if.sv
// Execute-stage side of the multiply/divide sequencer: request, operands and results.
interface alu_muldiv_sequencer_if #(
    parameter int WORDSIZE = 64
);
    logic                start;
    logic                op;
    logic [WORDSIZE-1:0] operand_a;
    logic [WORDSIZE-1:0] operand_b;
    logic                busy;
    logic                done;
    logic [WORDSIZE-1:0] result_lo;
    logic [WORDSIZE-1:0] result_hi;
    logic                div_by_zero;

    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, result_lo, result_hi, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, result_lo, result_hi, div_by_zero
    );
endinterface

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned MUL (low word) / DIVU controller that borrows the shared add/sub ALU,
// one shift-add or restoring-subtract iteration per cycle.
module alu_muldiv_sequencer #(
    parameter int WORDSIZE = 64
) (
    input  logic                clock,
    input  logic                reset,
    alu_muldiv_sequencer_if.slave bus,
    output logic [WORDSIZE-1:0] alu_input_a,
    output logic [WORDSIZE-1:0] alu_input_b,
    output logic [2:0]          alu_operation,
    input  logic [WORDSIZE-1:0] alu_result
);
    localparam int          CNT_W   = $clog2(WORDSIZE);
    localparam logic [2:0]  ALU_SUM = 3'b000;
    localparam logic [2:0]  ALU_SUB = 3'b001;

    typedef enum logic [1:0] {IDLE, MUL_STEP, DIV_STEP, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    count;
    // Datapath registers are shared: acc/rem, mcand/dvsr and mq/quo never live at the same time.
    logic [WORDSIZE-1:0] work_a;
    logic [WORDSIZE-1:0] work_b;
    logic [WORDSIZE-1:0] work_q;
    logic                dbz_latched;

    logic [WORDSIZE-1:0] shifted;
    logic                ge;
    logic                last_step;
    logic [WORDSIZE-1:0] acc_next;
    logic [WORDSIZE-1:0] rem_next;
    logic [WORDSIZE-1:0] quo_next;

    assign shifted   = {work_a[WORDSIZE-2:0], work_q[WORDSIZE-1]};
    // A set top bit means the true partial remainder exceeds WORDSIZE bits, so it beats any divisor.
    assign ge        = work_a[WORDSIZE-1] | (shifted >= work_b);
    assign last_step = (count == CNT_W'(WORDSIZE - 1));

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        alu_input_a   = '0;
        alu_input_b   = '0;
        alu_operation = ALU_SUM;
        case (state)
            MUL_STEP: begin
                alu_input_a = work_a;
                alu_input_b = work_b;
            end
            DIV_STEP: begin
                alu_input_a   = shifted;
                alu_input_b   = work_b;
                alu_operation = ALU_SUB;
            end
            default: ;
        endcase
    end

    // Next-value logic kept apart from the ALU drive: alu_result depends on alu_input_*.
    always_comb begin
        acc_next = work_q[0] ? alu_result : work_a;
        rem_next = ge ? alu_result : shifted;
        quo_next = {work_q[WORDSIZE-2:0], ge};
    end

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            count           <= '0;
            work_a          <= '0;
            work_b          <= '0;
            work_q          <= '0;
            dbz_latched     <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.result_lo   <= '0;
            bus.result_hi   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        count       <= '0;
                        bus.busy    <= 1'b1;
                        dbz_latched <= bus.op && (bus.operand_b == '0);
                        work_b      <= bus.operand_b;
                        if (bus.op) begin
                            state  <= DIV_STEP;
                            work_a <= '0;
                            work_q <= bus.operand_a;
                        end else begin
                            state  <= MUL_STEP;
                            work_a <= '0;
                            work_b <= bus.operand_a;
                            work_q <= bus.operand_b;
                        end
                    end
                end
                MUL_STEP: begin
                    work_a <= acc_next;
                    work_b <= work_b << 1;
                    work_q <= work_q >> 1;
                    count  <= count + CNT_W'(1);
                    if (last_step) begin
                        state           <= DONE;
                        bus.busy        <= 1'b0;
                        bus.done        <= 1'b1;
                        bus.result_lo   <= acc_next;
                        bus.result_hi   <= '0;
                        bus.div_by_zero <= 1'b0;
                    end
                end
                DIV_STEP: begin
                    work_a <= rem_next;
                    work_q <= quo_next;
                    count  <= count + CNT_W'(1);
                    if (last_step) begin
                        state           <= DONE;
                        bus.busy        <= 1'b0;
                        bus.done        <= 1'b1;
                        bus.result_lo   <= quo_next;
                        bus.result_hi   <= rem_next;
                        bus.div_by_zero <= dbz_latched;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Directed bench for alu_muldiv_sequencer (WORDSIZE=64) with a cycle-level arithmetic model
// and a per-cycle compare process; a simple add/sub ALU closes the loop.
module tb_alu_muldiv_sequencer;
    localparam int W = 64;

    logic         clock;
    logic         reset;
    logic [W-1:0] alu_input_a;
    logic [W-1:0] alu_input_b;
    logic [2:0]   alu_operation;
    logic [W-1:0] alu_result;

    alu_muldiv_sequencer_if #(.WORDSIZE(W)) bus ();

    alu_muldiv_sequencer #(.WORDSIZE(W)) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .alu_input_a   (alu_input_a),
        .alu_input_b   (alu_input_b),
        .alu_operation (alu_operation),
        .alu_result    (alu_result)
    );

    assign alu_result = (alu_operation == 3'b001) ? alu_input_a - alu_input_b
                                                  : alu_input_a + alu_input_b;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: an accepted op at edge e is busy for d=0..W-1 edges after e, done at d=W,
    // and the sequencer can accept again once d reaches W+2.
    int           cyc = 0;
    bit           m_active = 1'b0;
    int           m_edge = 0;
    bit           m_div = 1'b0;
    logic [W-1:0] p_lo, p_hi;
    bit           p_dbz;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] m_hi = '0;
    bit           m_dbz = 1'b0;

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            m_active = 1'b0;
            m_lo     = '0;
            m_hi     = '0;
            m_dbz    = 1'b0;
        end else if (bus.start && (!m_active || cyc - m_edge >= W + 2)) begin
            m_active = 1'b1;
            m_edge   = cyc;
            m_div    = bus.op;
            if (bus.op) begin
                p_dbz = (bus.operand_b == '0);
                p_lo  = p_dbz ? '1 : bus.operand_a / bus.operand_b;
                p_hi  = p_dbz ? bus.operand_a : bus.operand_a % bus.operand_b;
            end else begin
                p_lo  = bus.operand_a * bus.operand_b;
                p_hi  = '0;
                p_dbz = 1'b0;
            end
        end else if (m_active && cyc - m_edge == W) begin
            m_lo  = p_lo;
            m_hi  = p_hi;
            m_dbz = p_dbz;
        end
    end

    int done_pulses = 0;

    always @(negedge clock) begin
        if (cyc >= 1) begin
            int  d;
            bit  exp_busy, exp_done;
            d        = cyc - m_edge;
            exp_busy = m_active && d >= 0 && d <= W - 1;
            exp_done = m_active && d == W;
            if (bus.done) done_pulses++;
            check("busy", W'(bus.busy), W'(exp_busy));
            check("done", W'(bus.done), W'(exp_done));
            check("result_lo", bus.result_lo, m_lo);
            check("result_hi", bus.result_hi, m_hi);
            check("div_by_zero", W'(bus.div_by_zero), W'(m_dbz));
            check("alu_operation", W'(alu_operation), W'((exp_busy && m_div) ? 3'b001 : 3'b000));
            if (!exp_busy) begin
                check("alu_input_a_idle", alu_input_a, '0);
                check("alu_input_b_idle", alu_input_b, '0);
            end
        end
    end

    // Presents a request for one cycle, then scrambles the operands to show they were latched.
    task automatic issue(input logic op_i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start     = 1'b1;
        bus.op        = op_i;
        bus.operand_a = a;
        bus.operand_b = b;
        @(posedge clock); #1;
        bus.start     = 1'b0;
        bus.operand_a = ~a;
        bus.operand_b = ~b;
    endtask

    task automatic wait_done(output int edges, output int busy_cnt, output int sub_cnt);
        edges    = 0;
        busy_cnt = 0;
        sub_cnt  = 0;
        while (!bus.done && edges < 3 * W) begin
            if (bus.busy) busy_cnt++;
            if (bus.busy && alu_operation == 3'b001) sub_cnt++;
            @(posedge clock); #1;
            edges++;
        end
        if (!bus.done) check("done_timeout", '0, 64'd1);
    endtask

    task automatic step_cycles(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] vec_a [8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd5,
                                64'hDEAD_BEEF_0123_4567, 64'd0, 64'h0000_0001_0000_0000,
                                64'd12345, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [W-1:0] vec_b [8] = '{64'h8000_0000_0000_0001, 64'd3, 64'd9, 64'h1_0000,
                                64'd7, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};

    initial begin
        int edges, busy_cnt, sub_cnt, pulses0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.op        = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        step_cycles(3);
        reset = 1'b0;
        check("reset_busy", W'(bus.busy), '0);
        check("reset_done", W'(bus.done), '0);
        check("reset_result_lo", bus.result_lo, '0);
        check("reset_result_hi", bus.result_hi, '0);
        check("reset_dbz", W'(bus.div_by_zero), '0);

        // MUL 6*7: latency and busy width
        issue(1'b0, 64'd6, 64'd7);
        wait_done(edges, busy_cnt, sub_cnt);
        check("mul_done_edge", W'(edges + 1), 64'd65);
        check("mul_busy_cycles", W'(busy_cnt), 64'd64);
        check("mul_6x7_lo", bus.result_lo, 64'd42);
        check("mul_6x7_hi", bus.result_hi, 64'd0);
        step_cycles(1);
        check("done_one_cycle", W'(bus.done), '0);

        // MUL wrap, plus a start pulse during DONE that must be ignored
        issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        wait_done(edges, busy_cnt, sub_cnt);
        check("mul_wrap_lo", bus.result_lo, 64'hFFFF_FFFF_FFFF_FFFE);
        check("mul_wrap_hi", bus.result_hi, 64'd0);
        bus.start     = 1'b1;
        bus.op        = 1'b1;
        bus.operand_a = 64'd5;
        bus.operand_b = 64'd0;
        step_cycles(1);
        bus.start = 1'b0;
        check("start_in_done_ignored", W'(bus.busy), '0);

        // DIVU 100/7
        issue(1'b1, 64'd100, 64'd7);
        wait_done(edges, busy_cnt, sub_cnt);
        check("div_100_7_quo", bus.result_lo, 64'd14);
        check("div_100_7_rem", bus.result_hi, 64'd2);
        check("div_100_7_dbz", W'(bus.div_by_zero), '0);
        check("div_sub_cycles", W'(sub_cnt), 64'd64);
        step_cycles(1);

        // DIVU by zero
        issue(1'b1, 64'h1234, 64'd0);
        wait_done(edges, busy_cnt, sub_cnt);
        check("dbz_quo", bus.result_lo, '1);
        check("dbz_rem", bus.result_hi, 64'h1234);
        check("dbz_flag", W'(bus.div_by_zero), 64'd1);
        step_cycles(1);

        // start pulse mid-operation is ignored
        pulses0 = done_pulses;
        issue(1'b0, 64'd3, 64'd5);
        step_cycles(10);
        bus.start     = 1'b1;
        bus.op        = 1'b1;
        bus.operand_a = 64'd9;
        bus.operand_b = 64'd3;
        step_cycles(1);
        bus.start = 1'b0;
        wait_done(edges, busy_cnt, sub_cnt);
        check("mid_start_lo", bus.result_lo, 64'd15);
        step_cycles(6);
        check("mid_start_one_done", W'(done_pulses - pulses0), 64'd1);
        check("mid_start_idle", W'(bus.busy), '0);
        check("mid_start_hold", bus.result_lo, 64'd15);

        // reset mid-divide discards the operation
        issue(1'b1, 64'd50, 64'd5);
        step_cycles(20);
        reset = 1'b1;
        step_cycles(1);
        reset = 1'b0;
        check("abort_busy", W'(bus.busy), '0);
        check("abort_done", W'(bus.done), '0);
        check("abort_lo", bus.result_lo, '0);
        check("abort_hi", bus.result_hi, '0);
        pulses0 = done_pulses;
        step_cycles(70);
        check("abort_no_done", W'(done_pulses - pulses0), '0);
        issue(1'b0, 64'd4, 64'd4);
        wait_done(edges, busy_cnt, sub_cnt);
        check("after_abort_lo", bus.result_lo, 64'd16);
        step_cycles(1);

        // Edge-case operands for both ops, checked by the model every cycle
        for (int i = 0; i < 16; i++) begin
            issue(1'(i % 2), vec_a[i / 2], vec_b[i / 2]);
            wait_done(edges, busy_cnt, sub_cnt);
            step_cycles(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
